// File: rtl/dac_sweep_pkg.sv
// Shared encodings, FSM states and arithmetic helpers for the DAC sweep generator.
package dac_sweep_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WRITE, ST_DWELL, ST_NEXT, ST_DONE
  } state_t;

  function automatic int word_w(input int data_w);
    return 4 + data_w;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // One extra bit of headroom, clamped to [0, top].
  function automatic logic [31:0] sat_step(input logic [31:0] code, input logic [31:0] step,
                                           input logic sub, input logic [31:0] top);
    logic [32:0] sum;
    if (sub) begin
      sum = (step > code) ? 33'd0 : ({1'b0, code} - {1'b0, step});
    end else begin
      sum = {1'b0, code} + {1'b0, step};
      if (sum > {1'b0, top}) sum = {1'b0, top};
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/spi_dac_tx.sv
// Mode-0 SPI word serializer: MSB first, SCK half-period of SckHalf clocks,
// enforced chip-select gap; eow_o pulses once the gap has elapsed.
module spi_dac_tx #(
  parameter int WordW   = 16,
  parameter int SckHalf = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             strw_i,
  input  logic [WordW-1:0] din_i,
  output logic             mosi_o,
  output logic             sck_o,
  output logic             cs_o,
  output logic             eow_o
);

  localparam int DivW = $clog2(2 * SckHalf + 1);
  localparam int BitW = $clog2(WordW + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_LOW, TX_HIGH, TX_TRAIL, TX_GAP} tx_t;

  tx_t              st;
  logic [DivW-1:0]  div;
  logic [BitW-1:0]  nbit;
  logic [WordW-1:0] sreg;
  logic             half_end, gap_end;

  assign half_end = (div == DivW'(SckHalf - 1));
  assign gap_end  = (div == DivW'(2 * SckHalf - 1));
  assign mosi_o   = sreg[WordW-1];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st    <= TX_IDLE;
      div   <= '0;
      nbit  <= '0;
      sreg  <= '0;
      sck_o <= 1'b0;
      cs_o  <= 1'b1;
      eow_o <= 1'b0;
    end else begin
      eow_o <= 1'b0;
      case (st)
        TX_IDLE: if (strw_i) begin
          cs_o <= 1'b0;
          sreg <= din_i;
          div  <= '0;
          nbit <= '0;
          st   <= TX_LOW;
        end
        TX_LOW: if (half_end) begin
          div   <= '0;
          sck_o <= 1'b1;
          st    <= TX_HIGH;
        end else div <= div + DivW'(1);
        // data advances on the falling edge so it is stable across the rise
        TX_HIGH: if (half_end) begin
          div   <= '0;
          sck_o <= 1'b0;
          sreg  <= {sreg[WordW-2:0], 1'b0};
          if (nbit == BitW'(WordW - 1)) st <= TX_TRAIL;
          else begin
            nbit <= nbit + BitW'(1);
            st   <= TX_LOW;
          end
        end else div <= div + DivW'(1);
        TX_TRAIL: if (half_end) begin
          div  <= '0;
          cs_o <= 1'b1;
          st   <= TX_GAP;
        end else div <= div + DivW'(1);
        TX_GAP: if (gap_end) begin
          div   <= '0;
          eow_o <= 1'b1;
          st    <= TX_IDLE;
        end else div <= div + DivW'(1);
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dac_sweep_gen.sv
// Multi-channel staircase sweep generator: walks a programmed code sequence and
// writes every point to each enabled DAC channel over SPI.
module dac_sweep_gen
  import dac_sweep_pkg::*;
#(
  parameter int DataWidth  = 12,
  parameter int NumCh      = 2,
  parameter int CountWidth = 8,
  parameter int DwellWidth = 29,
  parameter int SckHalf    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [DataWidth-1:0]     start_code_i,
  input  logic [DataWidth-1:0]     step_i,
  input  logic [CountWidth-1:0]    nsteps_i,
  input  logic [DwellWidth-1:0]    dwell_i,
  input  logic [1:0]               mode_i,
  input  logic [NumCh-1:0]         ch_mask_i,
  input  logic [3-ch_w(NumCh):0]   cfg_i,
  output logic                     mosi_o,
  output logic                     sck_o,
  output logic                     cs_o,
  output logic                     busy_o,
  output logic [DataWidth-1:0]     code_o,
  output logic                     step_o,
  output logic                     eov_o
);

  localparam int WordW = word_w(DataWidth);
  localparam int ChW   = ch_w(NumCh);

  state_t                state;
  logic [1:0]            mode_q;
  logic [DataWidth-1:0]  step_q, nxt_code;
  logic [DwellWidth-1:0] dwell_q, dcnt;
  logic [NumCh-1:0]      mask_q;
  logic [3-ChW:0]        cfg_q;
  logic [CountWidth:0]   cnt;
  logic [CountWidth-1:0] half_q;
  logic [ChW-1:0]        ch, first_ch, nxt_ch;
  logic                  has_nxt, inflight, abort_pend, go_down, strw, eow;
  logic [WordW-1:0]      din;

  // Lowest enabled channel, and lowest enabled channel above the current one.
  always_comb begin
    first_ch = '0;
    nxt_ch   = '0;
    has_nxt  = 1'b0;
    for (int n = NumCh - 1; n >= 0; n--) begin
      if (mask_q[n]) first_ch = ChW'(n);
      if (mask_q[n] && n > int'(ch)) begin
        nxt_ch  = ChW'(n);
        has_nxt = 1'b1;
      end
    end
  end

  // Triangle climbs while more than half of the doubled count remains.
  always_comb begin
    case (mode_q)
      MODE_UP:   go_down = 1'b0;
      MODE_DOWN: go_down = 1'b1;
      MODE_TRI:  go_down = (cnt <= {1'b0, half_q});
      default:   go_down = 1'b0;
    endcase
  end

  assign nxt_code = DataWidth'(sat_step(32'(code_o), 32'(step_q), go_down,
                                        32'({DataWidth{1'b1}})));
  assign din      = {ch, cfg_q, code_o};
  assign strw     = (state == ST_WRITE) && !inflight;
  assign busy_o   = (state != ST_IDLE);

  spi_dac_tx #(.WordW(WordW), .SckHalf(SckHalf)) u_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .strw_i (strw),
    .din_i  (din),
    .mosi_o (mosi_o),
    .sck_o  (sck_o),
    .cs_o   (cs_o),
    .eow_o  (eow)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_UP;
      step_q     <= '0;
      dwell_q    <= '0;
      dcnt       <= '0;
      mask_q     <= '0;
      cfg_q      <= '0;
      cnt        <= '0;
      half_q     <= '0;
      ch         <= '0;
      inflight   <= 1'b0;
      abort_pend <= 1'b0;
      code_o     <= '0;
      step_o     <= 1'b0;
      eov_o      <= 1'b0;
    end else begin
      step_o <= 1'b0;
      eov_o  <= 1'b0;
      case (state)
        ST_IDLE: if (start_i && !abort_i && (ch_mask_i != '0)) begin
          mode_q     <= mode_i;
          step_q     <= step_i;
          dwell_q    <= (dwell_i == '0) ? DwellWidth'(1) : dwell_i;
          mask_q     <= ch_mask_i;
          cfg_q      <= cfg_i;
          code_o     <= start_code_i;
          half_q     <= nsteps_i;
          cnt        <= (mode_i == MODE_TRI) ? {nsteps_i, 1'b0} : {1'b0, nsteps_i};
          abort_pend <= 1'b0;
          state      <= ST_LOAD;
        end
        ST_LOAD: begin
          ch         <= first_ch;
          inflight   <= 1'b0;
          abort_pend <= abort_i;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (strw) inflight <= 1'b1;
          if (abort_i) abort_pend <= 1'b1;
          // an abort only takes effect once the word on the wire is finished
          if (eow) begin
            if (abort_pend || abort_i) state <= ST_IDLE;
            else if (has_nxt) begin
              ch       <= nxt_ch;
              inflight <= 1'b0;
            end else begin
              dcnt   <= '0;
              step_o <= 1'b1;
              state  <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          if (abort_i) state <= ST_IDLE;
          else if (dcnt == dwell_q - DwellWidth'(1)) state <= ST_NEXT;
          else dcnt <= dcnt + DwellWidth'(1);
        end
        ST_NEXT: begin
          if (abort_i) state <= ST_IDLE;
          else if (cnt == '0) begin
            eov_o <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt      <= cnt - (CountWidth + 1)'(1);
            code_o   <= nxt_code;
            ch       <= first_ch;
            inflight <= 1'b0;
            state    <= ST_WRITE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sweep_gen.sv
// Directed bench for dac_sweep_gen: decodes SPI words, checks mode-0 timing and sweep results.
module tb_dac_sweep_gen;

  localparam int SH = 4;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic [11:0] start_code = '0, step = '0;
  logic [7:0]  nsteps = '0;
  logic [28:0] dwell = '0;
  logic [1:0]  mode = '0, mask = '0;
  logic [2:0]  cfg = '0;
  logic        mosi, sck, cs, busy, step_p, eov;
  logic [11:0] code;

  dac_sweep_gen #(.DataWidth(12), .NumCh(2), .CountWidth(8), .DwellWidth(29), .SckHalf(SH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .start_code_i(start_code), .step_i(step), .nsteps_i(nsteps), .dwell_i(dwell),
    .mode_i(mode), .ch_mask_i(mask), .cfg_i(cfg),
    .mosi_o(mosi), .sck_o(sck), .cs_o(cs), .busy_o(busy), .code_o(code),
    .step_o(step_p), .eov_o(eov)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int tcyc = 0, spi_err = 0, nstep = 0, neov = 0, rise_cnt = 0, t_start = 0;
  int fall_t = 0, rise_t = 0, cs_fall_t = 0, cs_rise_t = 0, step_t = 0, last_dw = 0;
  bit in_word = 1'b0;
  logic [15:0] shreg = '0;
  logic [15:0] words[$];
  int bits_q[$];
  int step_at[$];
  logic p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [15:0] exp_up[4]   = '{16'h5064, 16'h5096, 16'h50C8, 16'h50FA};
  logic [15:0] exp_tri[10] = '{16'h2000, 16'hA000, 16'h23E8, 16'hA3E8, 16'h27D0,
                               16'hA7D0, 16'h23E8, 16'hA3E8, 16'h2000, 16'hA000};

  // SPI observer: samples registered outputs at each rising edge (values from the prior edge).
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        in_word   = 1'b0;
        rise_cnt  = 0;
        cs_rise_t = tcyc;
      end else begin
        if (step_p) begin
          nstep++;
          step_at.push_back(words.size());
          step_t = tcyc;
        end
        if (eov) neov++;
        if (p_cs && !cs) begin
          if (tcyc - cs_rise_t < 2 * SH) spi_err++;
          in_word   = 1'b1;
          rise_cnt  = 0;
          shreg     = '0;
          cs_fall_t = tcyc;
          fall_t    = tcyc;
          last_dw   = tcyc - step_t;
        end
        if (sck && (mosi !== p_mosi)) spi_err++;
        if (sck && cs) spi_err++;
        if (!p_sck && sck) begin
          if (tcyc - fall_t != SH) spi_err++;
          shreg = {shreg[14:0], mosi};
          rise_cnt++;
          rise_t = tcyc;
        end
        if (p_sck && !sck) begin
          if (tcyc - rise_t != SH) spi_err++;
          fall_t = tcyc;
        end
        if (!p_cs && cs && in_word) begin
          if (tcyc - fall_t != SH) spi_err++;
          words.push_back(shreg);
          bits_q.push_back(rise_cnt);
          in_word   = 1'b0;
          cs_rise_t = tcyc;
        end
      end
      p_sck = sck;
      p_cs  = cs;
      p_mosi = mosi;
      tcyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [11:0] sc, input logic [11:0] st, input logic [7:0] ns,
                    input logic [28:0] dw, input logic [1:0] md, input logic [1:0] mk,
                    input logic [2:0] cf);
    @(negedge clk);
    start_code = sc; step = st; nsteps = ns; dwell = dw; mode = md; mask = mk; cfg = cf;
    start = 1'b1;
    t_start = tcyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    for (int i = 0; i < lim && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clr();
    words.delete();
    bits_q.delete();
    step_at.delete();
    nstep = 0;
    neov = 0;
  endtask

  initial begin
    // reset state
    repeat (4) @(negedge clk);
    chk("rst_pins", {cs, sck, mosi, busy, step_p, eov}, 6'b100000);
    chk("rst_code", code, 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // up sweep, latency, start ignored while busy
    clr();
    go(12'd100, 12'd50, 8'd3, 29'd10, 2'b00, 2'b01, 3'b101);
    for (int i = 0; i < 20 && !in_word; i++) @(negedge clk);
    chk("latency", cs_fall_t - t_start, 3);
    for (int i = 0; i < 2000 && nstep == 0; i++) @(negedge clk);
    go(12'd7, 12'd1, 8'd9, 29'd3, 2'b01, 2'b11, 3'b000);
    wait_idle("up_idle", 4000);
    chk("up_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("up_word%0d", i), words[i], exp_up[i]);
    chk("up_bits", bits_q[3], 16);
    chk("up_steps", nstep, 4);
    chk("up_eov", neov, 1);
    chk("up_code", code, 12'd250);
    chk("up_dwell", last_dw, 12);

    // two-channel triangle
    clr();
    go(12'd0, 12'd1000, 8'd2, 29'd5, 2'b10, 2'b11, 3'b010);
    wait_idle("tri_idle", 6000);
    chk("tri_nwords", words.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("tri_word%0d", i), words[i], exp_tri[i]);
    chk("tri_steps", nstep, 5);
    chk("tri_pair0", step_at[0], 2);
    chk("tri_pair4", step_at[4], 10);
    chk("tri_eov", neov, 1);

    // saturation at full scale
    clr();
    go(12'd4000, 12'd200, 8'd2, 29'd4, 2'b00, 2'b01, 3'b000);
    wait_idle("sat_idle", 3000);
    chk("sat_nwords", words.size(), 3);
    chk("sat_w0", words[0], 16'h0FA0);
    chk("sat_w1", words[1], 16'h0FFF);
    chk("sat_w2", words[2], 16'h0FFF);
    chk("sat_steps", nstep, 3);
    chk("sat_eov", neov, 1);

    // single point
    clr();
    go(12'h123, 12'd9, 8'd0, 29'd3, 2'b00, 2'b01, 3'b111);
    wait_idle("n0_idle", 1000);
    chk("n0_nwords", words.size(), 1);
    chk("n0_word", words[0], 16'h7123);
    chk("n0_eov", neov, 1);

    // zero dwell behaves as one cycle; down sweep
    clr();
    go(12'd10, 12'd5, 8'd1, 29'd0, 2'b01, 2'b01, 3'b000);
    wait_idle("dw0_idle", 1000);
    chk("dw0_w0", words[0], 16'h000A);
    chk("dw0_w1", words[1], 16'h0005);
    chk("dw0_dwell", last_dw, 3);

    // empty mask and abort-with-start are both ignored
    clr();
    go(12'd1, 12'd1, 8'd1, 29'd1, 2'b00, 2'b00, 3'b000);
    repeat (10) @(negedge clk);
    chk("mask0_busy", busy, 0);
    abort = 1'b1;
    go(12'd1, 12'd1, 8'd1, 29'd1, 2'b00, 2'b01, 3'b000);
    repeat (10) @(negedge clk);
    abort = 1'b0;
    chk("abstart_busy", busy, 0);
    chk("ignored_nwords", words.size(), 0);

    // abort during the 2nd word
    clr();
    go(12'd100, 12'd50, 8'd3, 29'd10, 2'b00, 2'b01, 3'b101);
    for (int i = 0; i < 3000 && !(words.size() == 1 && in_word && rise_cnt >= 5); i++)
      @(negedge clk);
    chk("abort_arm", rise_cnt, 5);
    abort = 1'b1;
    wait_idle("abort_idle", 1000);
    abort = 1'b0;
    chk("abort_nwords", words.size(), 2);
    chk("abort_word", words[1], 16'h5096);
    chk("abort_bits", bits_q[1], 16);
    chk("abort_eov", neov, 0);
    chk("abort_code", code, 12'd150);

    // reset mid-word, then a clean word on channel 1
    clr();
    go(12'd500, 12'd1, 8'd2, 29'd2, 2'b00, 2'b01, 3'b001);
    for (int i = 0; i < 500 && !(in_word && rise_cnt >= 3); i++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_pins", {cs, sck, mosi, busy}, 4'b1000);
    chk("mrst_code", code, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    clr();
    go(12'h3AB, 12'd1, 8'd0, 29'd1, 2'b00, 2'b10, 3'b011);
    wait_idle("post_idle", 1000);
    chk("post_nwords", words.size(), 1);
    chk("post_word", words[0], 16'hB3AB);
    chk("post_bits", bits_q[0], 16);
    chk("post_eov", neov, 1);

    chk("spi_timing", spi_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_sweep_gen.md
Name: dac_sweep_gen

Overview:
Parametrised multi-channel staircase sweep generator for the bolometer bias DACs. It succeeds the single-channel fixed-step volts/steps sequencer. It runs a programmable sweep (start code, step size, step count, dwell time, up/down/triangle) and writes each point over SPI to every enabled DAC channel. It sits between the control FSM or button logic and the SPI DAC pins, and reports progress and end-of-sweep.

Parameters:
DataWidth, 12, DAC code width; SPI word width is WordW = 4 + DataWidth.
NumCh, 2, number of DAC channels (1, 2 or 4); ChW = max(1, clog2(NumCh)).
CountWidth, 8, width of the step count.
DwellWidth, 29, width of the dwell timer (29 bits gives 3 s at 100 MHz).
SckHalf, 4, SCK half-period in clk_i cycles (at least 1).

Ports:
clk_i  in  1  system clock; all logic is on the rising edge.
rst_i  in  1  synchronous, active-low reset.
start_i  in  1  single-cycle sweep start; ignored while busy_o=1.
abort_i  in  1  level; stops the sweep cleanly (see Behaviour).
start_code_i  in  DataWidth  first code of the sweep.
step_i  in  DataWidth  step magnitude (unsigned).
nsteps_i  in  CountWidth  number of steps after the start point.
dwell_i  in  DwellWidth  clk_i cycles held at each point; 0 is treated as 1.
mode_i  in  2  00 = up, 01 = down, 10 = triangle, 11 = reserved (treated as up).
ch_mask_i  in  NumCh  channel enable; bit n writes channel n.
cfg_i  in  4-ChW  DAC config bits (gain, shutdown) that fill the low bits of the header nibble.
mosi_o  out  1  SPI data.
sck_o  out  1  SPI clock.
cs_o  out  1  SPI chip select, active-low.
busy_o  out  1  high from start acceptance until return to IDLE.
code_o  out  DataWidth  code of the current point.
step_o  out  1  one-cycle pulse when every enabled channel has been written for a point.
eov_o  out  1  one-cycle pulse at normal sweep completion.

Behaviour:
- Reset (rst_i=0 at a rising edge): state IDLE, cs_o=1, sck_o=0, mosi_o=0, busy_o=0, code_o=0, step_o=0, eov_o=0, all counters cleared. Reset overrides everything, including an in-flight word.
- Inputs are latched on start acceptance only. Later changes to the inputs do not affect a running sweep.
- Start acceptance:
  - start_i=1 in IDLE with ch_mask_i≠0 moves to LOAD. busy_o rises the next cycle.
  - With ch_mask_i=0, start is ignored.
- FSM states: IDLE -> LOAD -> WRITE -> (next enabled channel ? WRITE : DWELL) -> NEXT -> WRITE ... -> DONE -> IDLE.
- LOAD: code_o = start_code_i; remaining-step counter = nsteps_i (doubled for triangle).
- WRITE: for each enabled channel, ascending index, send one word {ch_index[ChW-1:0], cfg_i, code_o}, MSB first.
- DWELL: hold for max(dwell_i, 1) cycles. step_o pulses on the first DWELL cycle.
- NEXT:
  - If the remaining count is 0, go to DONE.
  - Otherwise decrement the count and update the code: up adds step_i, down subtracts it.
  - Triangle goes up for the first nsteps_i steps, then down for nsteps_i steps.
  - Arithmetic is done at DataWidth+1 bits and saturates to [0, 2^DataWidth-1]. Saturation does not shorten the step count.
- DONE: eov_o=1 for one cycle, then IDLE. busy_o falls on the cycle after DONE.
- Points written: nsteps_i+1 (up/down) or 2*nsteps_i+1 (triangle). nsteps_i=0 writes the start code once, dwells, then finishes.
- SPI timing (mode 0):
  - cs_o falls one half-period before the first SCK rise.
  - mosi_o changes only while sck_o=0; sck_o idles low.
  - Each word has WordW rising edges of SCK_half-period SckHalf.
  - cs_o rises one half-period after the last fall.
  - cs_o stays high for at least 2*SckHalf cycles between words.
- Latency: the first cs_o fall occurs 2 cycles after start_i is sampled.
- Abort:
  - abort_i=1 in DWELL or NEXT goes straight to IDLE.
  - abort_i=1 during WRITE lets the current word complete (cs_o never rises mid-word), then goes to IDLE.
  - No eov_o on abort. code_o keeps the last written value.
- abort_i and start_i together in IDLE: start wins only if abort_i=0; abort has priority.
- busy_o=1 exactly while the state is not IDLE.

Decomposition:
- Package dac_sweep_pkg holds:
  - mode encodings MODE_UP, MODE_DOWN, MODE_TRI;
  - the FSM state enum;
  - the WordW derivation;
  - the saturating add/subtract function.
- Sub-module spi_dac_tx is the generic WordW-bit mode-0 serializer with SckHalf divider. Ports: strw_i, din_i, mosi_o, sck_o, cs_o, eow_o; eow_o is a 1-cycle pulse after cs_o rises and the gap completes.
- The top level holds the sweep FSM, dwell timer, step counter and channel walker.

Test Plan:
- Up sweep: start_code=100, step=50, nsteps=3, mode=00, mask=01, dwell=10 -> 4 words with codes 100/150/200/250 on ch0; 4 step_o pulses; one eov_o; busy_o low afterwards.
- Two-channel triangle: start=0, step=1000, nsteps=2, mode=10, mask=11 -> code sequence 0,1000,2000,1000,0. Each point sends header ch0 then ch1 (10 words total), and step_o follows each pair.
- Saturation: start=4000, step=200, mode=00, nsteps=2 -> codes 4000, 4095, 4095; step count unchanged; eov_o present.
- Abort mid-word: assert abort_i at the 5th SCK rise of word 2 -> all 16 bits complete, cs_o rises, IDLE, no eov_o, code_o holds word 2's value.
- Edge cases:
  - nsteps=0 -> single word, then eov_o.
  - mask=0 -> start ignored, busy_o stays 0.
  - start_i while busy -> ignored.
  - dwell=0 -> 1-cycle dwell.
- Reset: drive rst_i=0 during WRITE -> next cycle cs_o=1, sck_o=0, busy_o=0, code_o=0. A fresh start then produces a bit-exact first word; the SPI checker verifies mode-0 timing and the between-word gap.
